// File: rtl/eco32f_bus_arb_if.sv
// rtl/eco32f_bus_arb_if.sv - fetch/load-store requester ports and shared Wishbone master bundle
interface eco32f_bus_arb_if;
  logic        ibus_req;
  logic [31:0] ibus_adr;
  logic [31:0] ibus_dat;
  logic        ibus_ack;
  logic        ibus_err;

  logic        dbus_req;
  logic        dbus_we;
  logic [3:0]  dbus_sel;
  logic [31:0] dbus_adr;
  logic [31:0] dbus_dat_w;
  logic [31:0] dbus_dat_r;
  logic        dbus_ack;
  logic        dbus_err;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  // Arbiter side: consumes requests and slave responses, drives everything else.
  modport master (
    input  ibus_req, ibus_adr,
    input  dbus_req, dbus_we, dbus_sel, dbus_adr, dbus_dat_w,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output ibus_dat, ibus_ack, ibus_err,
    output dbus_dat_r, dbus_ack, dbus_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  // Environment side: requesters plus the Wishbone slave.
  modport slave (
    output ibus_req, ibus_adr,
    output dbus_req, dbus_we, dbus_sel, dbus_adr, dbus_dat_w,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  ibus_dat, ibus_ack, ibus_err,
    input  dbus_dat_r, dbus_ack, dbus_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );
endinterface

// File: rtl/eco32f_bus_arb.sv
// rtl/eco32f_bus_arb.sv - round-robin arbiter of fetch and load/store onto one Wishbone master
module eco32f_bus_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  eco32f_bus_arb_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_IBUS, S_DBUS} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        last_ibus_q, last_ibus_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;

  logic        iack_q, iack_d;
  logic        ierr_q, ierr_d;
  logic        dack_q, dack_d;
  logic        derr_q, derr_d;
  logic [31:0] idat_q, idat_d;
  logic [31:0] ddat_q, ddat_d;

  logic        pulse_busy;
  logic        tmo;
  logic        done;
  logic        ack_ok;
  logic        err_out;

  // A requester still holds req during its completion pulse, so no grant is
  // allowed while any pulse is visible or that stale request would re-win.
  assign pulse_busy = iack_q | ierr_q | dack_q | derr_q;
  assign tmo        = (cnt_q == TMO_LAST);
  assign done       = bus.wb_ack_i | bus.wb_err_i | tmo;
  assign ack_ok     = bus.wb_ack_i & ~bus.wb_err_i;
  assign err_out    = bus.wb_err_i | (~bus.wb_ack_i & tmo);

  // Next-state, bus latching, completion pulses and timeout counting.
  always_comb begin
    state_d     = state_q;
    last_ibus_d = last_ibus_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    wdat_d      = wdat_q;
    iack_d      = 1'b0;
    ierr_d      = 1'b0;
    dack_d      = 1'b0;
    derr_d      = 1'b0;
    idat_d      = idat_q;
    ddat_d      = ddat_q;

    case (state_q)
      S_IDLE: begin
        if (!pulse_busy) begin
          if (bus.dbus_req && (!bus.ibus_req || last_ibus_q)) begin
            state_d     = S_DBUS;
            last_ibus_d = 1'b0;
            cnt_d       = 8'd0;
            cyc_d       = 1'b1;
            stb_d       = 1'b1;
            we_d        = bus.dbus_we;
            sel_d       = bus.dbus_sel;
            adr_d       = bus.dbus_adr;
            wdat_d      = bus.dbus_dat_w;
          end else if (bus.ibus_req) begin
            state_d     = S_IBUS;
            last_ibus_d = 1'b1;
            cnt_d       = 8'd0;
            cyc_d       = 1'b1;
            stb_d       = 1'b1;
            we_d        = 1'b0;
            sel_d       = 4'hf;
            adr_d       = bus.ibus_adr;
            wdat_d      = 32'd0;
          end
        end
      end
      S_IBUS, S_DBUS: begin
        if (done) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          we_d    = 1'b0;
          sel_d   = 4'h0;
          adr_d   = 32'd0;
          wdat_d  = 32'd0;
          if (state_q == S_IBUS) begin
            iack_d = ack_ok;
            ierr_d = err_out;
            if (bus.wb_ack_i || bus.wb_err_i) idat_d = bus.wb_dat_i;
          end else begin
            dack_d = ack_ok;
            derr_d = err_out;
            if (bus.wb_ack_i || bus.wb_err_i) ddat_d = bus.wb_dat_i;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any transaction without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_ibus_q <= 1'b1;
      cnt_q       <= 8'd0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= 4'h0;
      adr_q       <= 32'd0;
      wdat_q      <= 32'd0;
      iack_q      <= 1'b0;
      ierr_q      <= 1'b0;
      dack_q      <= 1'b0;
      derr_q      <= 1'b0;
      idat_q      <= 32'd0;
      ddat_q      <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_ibus_q <= last_ibus_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      iack_q      <= iack_d;
      ierr_q      <= ierr_d;
      dack_q      <= dack_d;
      derr_q      <= derr_d;
      idat_q      <= idat_d;
      ddat_q      <= ddat_d;
    end
  end

  assign bus.wb_cyc_o   = cyc_q;
  assign bus.wb_stb_o   = stb_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = wdat_q;
  assign bus.ibus_ack   = iack_q;
  assign bus.ibus_err   = ierr_q;
  assign bus.ibus_dat   = idat_q;
  assign bus.dbus_ack   = dack_q;
  assign bus.dbus_err   = derr_q;
  assign bus.dbus_dat_r = ddat_q;

endmodule

// File: tb/tb_eco32f_bus_arb.sv
// tb/tb_eco32f_bus_arb.sv - directed self-checking bench for eco32f_bus_arb
`timescale 1ns/1ps
module tb_eco32f_bus_arb;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  eco32f_bus_arb_if bus ();

  eco32f_bus_arb #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    bus.ibus_req   = 1'b0;
    bus.ibus_adr   = 32'd0;
    bus.dbus_req   = 1'b0;
    bus.dbus_we    = 1'b0;
    bus.dbus_sel   = 4'h0;
    bus.dbus_adr   = 32'd0;
    bus.dbus_dat_w = 32'd0;
    bus.wb_dat_i   = 32'd0;
    bus.wb_ack_i   = 1'b0;
    bus.wb_err_i   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cyc", {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, bus.wb_stb_o}, 32'd0);
    chk("rst_we", {31'd0, bus.wb_we_o}, 32'd0);
    chk("rst_sel", {28'd0, bus.wb_sel_o}, 32'd0);
    chk("rst_adr", bus.wb_adr_o, 32'd0);
    chk("rst_pulses", {28'd0, bus.ibus_ack, bus.ibus_err, bus.dbus_ack, bus.dbus_err}, 32'd0);
    chk("rst_idat", bus.ibus_dat, 32'd0);
    chk("rst_ddat", bus.dbus_dat_r, 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    bus.ibus_req = 1'b1;
    bus.ibus_adr = 32'h0000_1000;
    tick();
    chk("rd_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    chk("rd_stb", {31'd0, bus.wb_stb_o}, 32'd1);
    chk("rd_adr", bus.wb_adr_o, 32'h0000_1000);
    chk("rd_we", {31'd0, bus.wb_we_o}, 32'd0);
    chk("rd_sel", {28'd0, bus.wb_sel_o}, 32'hf);
    chk("rd_dato", bus.wb_dat_o, 32'd0);
    tick();
    chk("rd_wait_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    chk("rd_wait_ack", {31'd0, bus.ibus_ack}, 32'd0);
    tick();
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hDEAD_BEEF;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h0;
    chk("rd_ack", {31'd0, bus.ibus_ack}, 32'd1);
    chk("rd_err", {31'd0, bus.ibus_err}, 32'd0);
    chk("rd_dack", {31'd0, bus.dbus_ack}, 32'd0);
    chk("rd_dat", bus.ibus_dat, 32'hDEAD_BEEF);
    chk("rd_cyc_drop", {31'd0, bus.wb_cyc_o}, 32'd0);
    bus.ibus_req = 1'b0;
    tick();
    chk("rd_ack_once", {31'd0, bus.ibus_ack}, 32'd0);
    chk("rd_dat_hold", bus.ibus_dat, 32'hDEAD_BEEF);
    tick();
    chk("rd_no_regrant", {31'd0, bus.wb_cyc_o}, 32'd0);
  endtask

  task automatic test_store();
    bus.dbus_req   = 1'b1;
    bus.dbus_we    = 1'b1;
    bus.dbus_sel   = 4'b0011;
    bus.dbus_adr   = 32'h8000_0004;
    bus.dbus_dat_w = 32'h1234_5678;
    tick();
    chk("st_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    chk("st_we", {31'd0, bus.wb_we_o}, 32'd1);
    chk("st_sel", {28'd0, bus.wb_sel_o}, 32'h3);
    chk("st_adr", bus.wb_adr_o, 32'h8000_0004);
    chk("st_dato", bus.wb_dat_o, 32'h1234_5678);
    bus.dbus_adr   = 32'h0;
    bus.dbus_dat_w = 32'h0;
    bus.dbus_sel   = 4'hf;
    bus.dbus_we    = 1'b0;
    tick();
    chk("st_hold_adr", bus.wb_adr_o, 32'h8000_0004);
    chk("st_hold_dat", bus.wb_dat_o, 32'h1234_5678);
    chk("st_hold_sel", {28'd0, bus.wb_sel_o}, 32'h3);
    bus.wb_err_i = 1'b1;
    tick();
    bus.wb_err_i = 1'b0;
    chk("st_err", {31'd0, bus.dbus_err}, 32'd1);
    chk("st_noack", {31'd0, bus.dbus_ack}, 32'd0);
    chk("st_no_ierr", {31'd0, bus.ibus_err}, 32'd0);
    chk("st_cyc_drop", {31'd0, bus.wb_cyc_o}, 32'd0);
    bus.dbus_req = 1'b0;
    tick();
    chk("st_err_once", {30'd0, bus.dbus_err, bus.dbus_ack}, 32'd0);
    tick();
  endtask

  task automatic test_contention();
    logic [31:0] order [4];
    logic [31:0] want [4];
    int   n_grants;
    int   gap;
    logic prev_cyc;
    want[0] = 32'h200; want[1] = 32'h100; want[2] = 32'h200; want[3] = 32'h100;
    idle_inputs();
    rst = 1'b1;
    tick();
    bus.ibus_req = 1'b1;
    bus.ibus_adr = 32'h100;
    bus.dbus_req = 1'b1;
    bus.dbus_adr = 32'h200;
    rst = 1'b0;
    n_grants = 0;
    gap      = 1;
    prev_cyc = 1'b0;
    for (int c = 0; c < 40 && n_grants < 4; c++) begin
      tick();
      if (bus.wb_cyc_o && !prev_cyc) begin
        order[n_grants] = bus.wb_adr_o;
        if (n_grants > 0) chk("ct_gap", {31'd0, gap >= 1}, 32'd1);
        n_grants++;
        gap = 0;
      end else if (!bus.wb_cyc_o) begin
        gap++;
      end
      if (bus.ibus_ack) chk("ct_iack_owner", order[n_grants-1], 32'h100);
      if (bus.dbus_ack) chk("ct_dack_owner", order[n_grants-1], 32'h200);
      prev_cyc     = bus.wb_cyc_o;
      bus.wb_ack_i = bus.wb_cyc_o;
    end
    chk("ct_n_grants", n_grants, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_grants) chk("ct_order", order[i], want[i]);
    end
    bus.ibus_req = 1'b0;
    bus.dbus_req = 1'b0;
    tick();
    bus.wb_ack_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cyc_cnt;
    int ierr_cnt;
    int other_cnt;
    cyc_cnt   = 0;
    ierr_cnt  = 0;
    other_cnt = 0;
    bus.ibus_req = 1'b1;
    bus.ibus_adr = 32'h0000_2000;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.wb_cyc_o) cyc_cnt++;
      if (bus.ibus_err) begin
        ierr_cnt++;
        bus.ibus_req = 1'b0;
      end
      if (bus.ibus_ack || bus.dbus_ack || bus.dbus_err) other_cnt++;
    end
    chk("to_active_cycles", cyc_cnt, 32'd4);
    chk("to_err_pulses", ierr_cnt, 32'd1);
    chk("to_other_pulses", other_cnt, 32'd0);
    chk("to_cyc_low", {31'd0, bus.wb_cyc_o}, 32'd0);
    bus.ibus_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.dbus_req   = 1'b1;
    bus.dbus_we    = 1'b0;
    bus.dbus_sel   = 4'hf;
    bus.dbus_adr   = 32'h0000_0040;
    tick();
    chk("rm_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_cyc_drop", {31'd0, bus.wb_cyc_o}, 32'd0);
    chk("rm_no_pulse", {30'd0, bus.dbus_ack, bus.dbus_err}, 32'd0);
    bus.dbus_adr = 32'h0000_0300;
    tick();
    chk("rm_regrant_cyc", {31'd0, bus.wb_cyc_o}, 32'd1);
    chk("rm_regrant_adr", bus.wb_adr_o, 32'h0000_0300);
    chk("rm_still_no_pulse", {30'd0, bus.dbus_ack, bus.dbus_err}, 32'd0);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hCAFE_0001;
    tick();
    bus.wb_ack_i = 1'b0;
    bus.dbus_req = 1'b0;
    chk("rm_ack", {31'd0, bus.dbus_ack}, 32'd1);
    chk("rm_dat", bus.dbus_dat_r, 32'hCAFE_0001);
    tick();
    chk("rm_ack_once", {31'd0, bus.dbus_ack}, 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
    test_read();
    test_store();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
